// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one registered ALU (one-cycle latency) between two
// requesters. Round-robin grant, one outstanding op per requester, a one-deep
// result holding register per requester, and illegal function codes are
// filtered so the ALU only ever sees 0 (hold) or a legal code 1..9.
module alu_share_arbiter #(
    parameter int DW = 32,
    parameter int SW = 5,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // requester 0
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic [DW-1:0] req0_a,
    input  logic [DW-1:0] req0_b,
    input  logic [SW-1:0] req0_shamt,
    input  logic [FW-1:0] req0_funct,
    // requester 1
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic [DW-1:0] req1_a,
    input  logic [DW-1:0] req1_b,
    input  logic [SW-1:0] req1_shamt,
    input  logic [FW-1:0] req1_funct,
    // response 0
    output logic          rsp0_valid,
    input  logic          rsp0_ready,
    output logic [DW-1:0] rsp0_data,
    output logic          rsp0_err,
    // response 1
    output logic          rsp1_valid,
    input  logic          rsp1_ready,
    output logic [DW-1:0] rsp1_data,
    output logic          rsp1_err,
    // shared ALU
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [SW-1:0] alu_shamt,
    output logic [FW-1:0] alu_funct,
    input  logic [DW-1:0] alu_res
);

    // Code 0 makes the ALU hold its result; 1..9 are the implemented ops.
    localparam logic [FW-1:0] FUNCT_NOP  = '0;
    localparam logic [FW-1:0] FUNCT_LAST = FW'(9);

    // ------------------------------------------------------------------
    // Per-requester views of the flat ports, indexed by requester number
    // ------------------------------------------------------------------
    logic [1:0]    req_valid;
    logic [1:0]    rsp_ready;
    logic [DW-1:0] req_a     [2];
    logic [DW-1:0] req_b     [2];
    logic [SW-1:0] req_shamt [2];
    logic [FW-1:0] req_funct [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign rsp_ready    = {rsp1_ready, rsp0_ready};
    assign req_a[0]     = req0_a;
    assign req_a[1]     = req1_a;
    assign req_b[0]     = req0_b;
    assign req_b[1]     = req1_b;
    assign req_shamt[0] = req0_shamt;
    assign req_shamt[1] = req1_shamt;
    assign req_funct[0] = req0_funct;
    assign req_funct[1] = req1_funct;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic          rr_ptr_q,      rr_ptr_d;      // requester favoured on a tie
    logic [1:0]    inflight_q,    inflight_d;    // op presented to ALU last cycle
    logic [1:0]    pend_err_q,    pend_err_d;    // that op had an illegal funct
    logic [1:0]    rsp_valid_q,   rsp_valid_d;
    logic [1:0]    rsp_err_q,     rsp_err_d;
    logic [DW-1:0] rsp_data_q [2];
    logic [DW-1:0] rsp_data_d [2];

    // Arbitration signals
    logic [1:0]    free;
    logic [1:0]    eligible;
    logic [1:0]    grant;
    logic          gnt_any;
    logic          gnt_idx;
    logic [FW-1:0] gnt_funct;
    logic          gnt_legal;

    // Round-robin arbitration: pick at most one eligible requester per cycle.
    // NOTE: every variable assigned in an always_comb gets a default at the top,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        free     = ~inflight_q & (~rsp_valid_q | rsp_ready);
        // Nothing is accepted while reset is asserted: the state that would
        // record the acceptance is being held clear.
        eligible = req_valid & free & {2{rst_n}};
        grant    = 2'b00;
        if (&eligible) begin
            grant[rr_ptr_q] = 1'b1;
        end else begin
            grant = eligible;
        end
        gnt_any  = |grant;
        gnt_idx  = grant[1];
        rr_ptr_d = gnt_any ? ~gnt_idx : rr_ptr_q;
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    // Drive the ALU from the granted requester; illegal codes become a hold.
    always_comb begin
        gnt_funct = req_funct[gnt_idx];
        gnt_legal = (gnt_funct != FUNCT_NOP) && (gnt_funct <= FUNCT_LAST);
        alu_a     = '0;
        alu_b     = '0;
        alu_shamt = '0;
        alu_funct = FUNCT_NOP;
        if (gnt_any) begin
            alu_a     = req_a[gnt_idx];
            alu_b     = req_b[gnt_idx];
            alu_shamt = req_shamt[gnt_idx];
            alu_funct = gnt_legal ? gnt_funct : FUNCT_NOP;
        end
    end

    // Track in-flight ops and capture ALU results into the holding registers.
    always_comb begin
        // A requester is never granted while its op is in flight, so the
        // in-flight flag lasts exactly the one cycle the ALU needs.
        inflight_d  = grant;
        pend_err_d  = pend_err_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;
        for (int k = 0; k < 2; k++) begin
            if (grant[k]) begin
                pend_err_d[k] = ~gnt_legal;
            end
            // A landing result takes priority over the consumer draining the
            // previous one at the same edge.
            if (inflight_q[k]) begin
                rsp_valid_d[k] = 1'b1;
                rsp_err_d[k]   = pend_err_q[k];
                rsp_data_d[k]  = pend_err_q[k] ? '0 : alu_res;
            end else if (rsp_ready[k]) begin
                rsp_valid_d[k] = 1'b0;
            end
        end
    end

    // State registers; reset discards in-flight ops and held results.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= 1'b0;
            inflight_q  <= '0;
            pend_err_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= '0;
            for (int k = 0; k < 2; k++) begin
                rsp_data_q[k] <= '0;
            end
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            inflight_q  <= inflight_d;
            pend_err_q  <= pend_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // Structural invariants of the arbiter.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(&grant));
            assert ((grant & inflight_q) == 2'b00);
            assert (alu_funct <= FUNCT_LAST);
        end
    end

    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_data  = rsp_data_q[1];
    assign rsp0_err   = rsp_err_q[0];
    assign rsp1_err   = rsp_err_q[1];

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: a registered ALU model, a table
// of directed cycles, hand-written corner sequences and a randomized run
// compared against a transaction-level reference model.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [4:0]  req0_shamt, req1_shamt;
    logic [3:0]  req0_funct, req1_funct;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic [31:0] alu_a, alu_b;
    logic [4:0]  alu_shamt;
    logic [3:0]  alu_funct;
    logic [31:0] alu_res = '0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DW(32), .SW(5), .FW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_shamt(req0_shamt), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_shamt(req1_shamt), .req1_funct(req1_funct),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_res(alu_res)
    );

    // Behavioural ALU function (shift amount 0 means shift by b[0]).
    function automatic logic [31:0] alu_fn(input logic [3:0] f, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        logic [4:0]  amt;
        logic [31:0] r;
        amt = (sh == 5'd0) ? {4'd0, b[0]} : sh;
        case (f)
            4'd1:    r = a + b;
            4'd2:    r = a - b;
            4'd3:    r = a & b;
            4'd4:    r = a | b;
            4'd5:    r = a ^ b;
            4'd6:    r = ~a;
            4'd7:    r = a << amt;
            4'd8:    r = $signed(a) >>> amt;
            4'd9:    r = a >> amt;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Registered ALU: one-cycle latency, holds its result on funct 0.
    always @(posedge clk) begin
        if (alu_funct != 4'd0) alu_res <= alu_fn(alu_funct, alu_a, alu_b, alu_shamt);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int k, input logic v, input logic [3:0] f,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        if (k == 0) begin
            req0_valid = v; req0_funct = f; req0_a = a; req0_b = b; req0_shamt = sh;
        end else begin
            req1_valid = v; req1_funct = f; req1_a = a; req1_b = b; req1_shamt = sh;
        end
    endtask

    task automatic idle_inputs();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        repeat (4) tick();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Randomized run against a transaction-level model: each requester has an
    // op "in the ALU" or a result "on display"; priority goes to whichever
    // requester did not win the most recent grant.
    task automatic run_random(input int ncyc);
        bit          busy[2], hv[2], he[2], perr[2], v[2], rr[2], fr[2], legal;
        logic [31:0] pdata[2], hd[2], a[2], b[2];
        logic [3:0]  f[2];
        logic [4:0]  sh[2];
        int          favoured, winner;
        logic [3:0]  e_funct;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_sh;
        favoured = 0;
        for (int k = 0; k < 2; k++) begin
            busy[k] = 0; hv[k] = 0; he[k] = 0; perr[k] = 0; pdata[k] = '0; hd[k] = '0;
        end
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                v[k]  = ($urandom % 10) < 7;
                rr[k] = ($urandom % 10) < 6;
                if (($urandom % 8) == 0)
                    f[k] = (($urandom % 4) == 0) ? 4'd0 : 4'($urandom_range(10, 15));
                else
                    f[k] = 4'($urandom_range(1, 9));
                a[k]  = $urandom;
                b[k]  = $urandom;
                sh[k] = 5'($urandom);
                drive_req(k, v[k], f[k], a[k], b[k], sh[k]);
                fr[k] = !busy[k] && (!hv[k] || rr[k]);
            end
            rsp0_ready = rr[0];
            rsp1_ready = rr[1];
            winner = -1;
            if (v[0] && fr[0] && v[1] && fr[1]) winner = favoured;
            else if (v[0] && fr[0])             winner = 0;
            else if (v[1] && fr[1])             winner = 1;
            e_funct = '0; e_a = '0; e_b = '0; e_sh = '0;
            if (winner >= 0) begin
                e_a = a[winner]; e_b = b[winner]; e_sh = sh[winner];
                e_funct = (f[winner] >= 4'd1 && f[winner] <= 4'd9) ? f[winner] : 4'd0;
            end
            @(negedge clk);
            check("rnd_req0_ready", 32'(req0_ready), 32'(winner == 0));
            check("rnd_req1_ready", 32'(req1_ready), 32'(winner == 1));
            check("rnd_alu_funct", 32'(alu_funct), 32'(e_funct));
            check("rnd_alu_a", alu_a, e_a);
            check("rnd_alu_b", alu_b, e_b);
            check("rnd_alu_shamt", 32'(alu_shamt), 32'(e_sh));
            check("rnd_rsp0_valid", 32'(rsp0_valid), 32'(hv[0]));
            check("rnd_rsp1_valid", 32'(rsp1_valid), 32'(hv[1]));
            if (hv[0]) begin
                check("rnd_rsp0_data", rsp0_data, hd[0]);
                check("rnd_rsp0_err", 32'(rsp0_err), 32'(he[0]));
            end
            if (hv[1]) begin
                check("rnd_rsp1_data", rsp1_data, hd[1]);
                check("rnd_rsp1_err", 32'(rsp1_err), 32'(he[1]));
            end
            for (int k = 0; k < 2; k++) begin
                if (busy[k]) begin
                    hv[k] = 1; hd[k] = pdata[k]; he[k] = perr[k]; busy[k] = 0;
                end else if (rr[k]) begin
                    hv[k] = 0;
                end
                if (winner == k) begin
                    legal    = (f[k] >= 4'd1) && (f[k] <= 4'd9);
                    busy[k]  = 1;
                    perr[k]  = !legal;
                    pdata[k] = legal ? alu_fn(f[k], a[k], b[k], sh[k]) : 32'd0;
                end
            end
            if (winner >= 0) favoured = 1 - winner;
            tick();
        end
    endtask

    typedef struct packed {
        logic        rdy0;
        logic        rdy1;
        logic [3:0]  funct;
        logic [31:0] alu_a;
        logic        rv0;
        logic [31:0] rd0;
        logic        rv1;
        logic [31:0] rd1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int last, max_gap, n_g1;

        // Both requesters valid every cycle from reset: SUB 3-5 and SRA 0x80000000>>>4.
        tbl[0] = '{1'b1, 1'b0, 4'd2, 32'd3,         1'b0, 32'd0,         1'b0, 32'd0};
        tbl[1] = '{1'b0, 1'b1, 4'd8, 32'h8000_0000, 1'b0, 32'd0,         1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b0, 4'd2, 32'd3,         1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0};
        tbl[3] = '{1'b0, 1'b1, 4'd8, 32'h8000_0000, 1'b0, 32'd0,         1'b1, 32'hF800_0000};
        tbl[4] = '{1'b1, 1'b0, 4'd2, 32'd3,         1'b1, 32'hFFFF_FFFE, 1'b0, 32'd0};
        tbl[5] = '{1'b0, 1'b1, 4'd8, 32'h8000_0000, 1'b0, 32'd0,         1'b1, 32'hF800_0000};

        // Reset values
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_data", rsp0_data, 32'd0);
        check("rst_rsp1_data", rsp1_data, 32'd0);
        check("rst_rsp0_err", 32'(rsp0_err), 32'd0);
        check("rst_rsp1_err", 32'(rsp1_err), 32'd0);
        check("rst_alu_funct", 32'(alu_funct), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        check("rst_alu_shamt", 32'(alu_shamt), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Table: alternating grants with continuous demand
        drive_req(0, 1'b1, 4'd2, 32'd3, 32'd5, 5'd0);
        drive_req(1, 1'b1, 4'd8, 32'h8000_0000, 32'd0, 5'd4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("tbl%0d_req0_ready", i), 32'(req0_ready), 32'(tbl[i].rdy0));
            check($sformatf("tbl%0d_req1_ready", i), 32'(req1_ready), 32'(tbl[i].rdy1));
            check($sformatf("tbl%0d_alu_funct", i), 32'(alu_funct), 32'(tbl[i].funct));
            check($sformatf("tbl%0d_alu_a", i), alu_a, tbl[i].alu_a);
            check($sformatf("tbl%0d_rsp0_valid", i), 32'(rsp0_valid), 32'(tbl[i].rv0));
            check($sformatf("tbl%0d_rsp1_valid", i), 32'(rsp1_valid), 32'(tbl[i].rv1));
            if (tbl[i].rv0) check($sformatf("tbl%0d_rsp0_data", i), rsp0_data, tbl[i].rd0);
            if (tbl[i].rv1) check($sformatf("tbl%0d_rsp1_data", i), rsp1_data, tbl[i].rd1);
            tick();
        end
        drain();

        // Single ADD: accept, 2-cycle latency, hold until consumed
        drive_req(0, 1'b1, 4'd1, 32'd5, 32'd7, 5'd0);
        rsp0_ready = 1'b0;
        @(negedge clk);
        check("single_ready", 32'(req0_ready), 32'd1);
        check("single_alu_funct", 32'(alu_funct), 32'd1);
        check("single_alu_a", alu_a, 32'd5);
        check("single_alu_b", alu_b, 32'd7);
        tick();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check("single_funct_after", 32'(alu_funct), 32'd0);
        check("single_rsp_early", 32'(rsp0_valid), 32'd0);
        tick();
        @(negedge clk);
        check("single_rsp_valid", 32'(rsp0_valid), 32'd1);
        check("single_rsp_data", rsp0_data, 32'd12);
        check("single_rsp_err", 32'(rsp0_err), 32'd0);
        tick();
        @(negedge clk);
        check("single_hold_valid", 32'(rsp0_valid), 32'd1);
        check("single_hold_data", rsp0_data, 32'd12);
        tick();
        rsp0_ready = 1'b1;
        @(negedge clk);
        check("single_consume_valid", 32'(rsp0_valid), 32'd1);
        tick();
        @(negedge clk);
        check("single_cleared", 32'(rsp0_valid), 32'd0);
        drain();

        // Illegal funct 12: accepted, ALU held, data 0 err 1
        drive_req(0, 1'b1, 4'd12, 32'h0000_DEAD, 32'd1, 5'd3);
        @(negedge clk);
        check("illegal_ready", 32'(req0_ready), 32'd1);
        check("illegal_alu_funct", 32'(alu_funct), 32'd0);
        tick();
        drive_req(0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check("illegal_rsp_early", 32'(rsp0_valid), 32'd0);
        tick();
        @(negedge clk);
        check("illegal_rsp_valid", 32'(rsp0_valid), 32'd1);
        check("illegal_rsp_data", rsp0_data, 32'd0);
        check("illegal_rsp_err", 32'(rsp0_err), 32'd1);
        drain();

        // Backpressure on requester 1
        drive_req(1, 1'b1, 4'd1, 32'd1, 32'd2, 5'd0);
        rsp1_ready = 1'b0;
        @(negedge clk);
        check("bp_accept", 32'(req1_ready), 32'd1);
        tick();
        drive_req(1, 1'b1, 4'd4, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        @(negedge clk);
        check("bp_inflight_ready", 32'(req1_ready), 32'd0);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(rsp1_valid), 32'd1);
            check("bp_hold_data", rsp1_data, 32'd3);
            check("bp_blocked_ready", 32'(req1_ready), 32'd0);
            tick();
        end
        rsp1_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(req1_ready), 32'd1);
        check("bp_release_funct", 32'(alu_funct), 32'd4);
        check("bp_release_data", rsp1_data, 32'd3);
        tick();
        drive_req(1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check("bp_gap_valid", 32'(rsp1_valid), 32'd0);
        tick();
        @(negedge clk);
        check("bp_new_valid", 32'(rsp1_valid), 32'd1);
        check("bp_new_data", rsp1_data, 32'h0000_00FF);
        drain();

        // Fairness: req1 always valid, req0 toggling
        last = -1; max_gap = 0; n_g1 = 0;
        for (int i = 0; i < 24; i++) begin
            drive_req(1, 1'b1, 4'd1, 32'(i), 32'd1, 5'd0);
            drive_req(0, (i % 2) == 0, 4'd3, 32'hFFFF_0000, 32'(i), 5'd0);
            @(negedge clk);
            if (req1_ready) begin
                if (i - last > max_gap) max_gap = i - last;
                last = i;
                n_g1++;
            end
            tick();
        end
        check("fair_req1_gap_ok", 32'(max_gap <= 3), 32'd1);
        check("fair_req1_grants_ok", 32'(n_g1 >= 8), 32'd1);
        drain();

        // Reset one cycle after accepting req1 XOR
        drive_req(1, 1'b1, 4'd5, 32'h0000_FF00, 32'h0000_0FF0, 5'd0);
        @(negedge clk);
        check("rstop_accept", 32'(req1_ready), 32'd1);
        check("rstop_funct", 32'(alu_funct), 32'd5);
        tick();
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rstop_rsp1_valid_in_reset", 32'(rsp1_valid), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rstop_rsp1_valid", 32'(rsp1_valid), 32'd0);
            check("rstop_rsp1_data", rsp1_data, 32'd0);
            check("rstop_rsp1_err", 32'(rsp1_err), 32'd0);
            check("rstop_rsp0_valid", 32'(rsp0_valid), 32'd0);
            tick();
        end

        // Round-robin pointer returns to requester 0 on reset
        drive_req(0, 1'b1, 4'd1, 32'd1, 32'd1, 5'd0);
        @(negedge clk);
        check("rr_pre_grant0", 32'(req0_ready), 32'd1);
        tick();
        drain();
        do_reset();
        drive_req(0, 1'b1, 4'd1, 32'd2, 32'd2, 5'd0);
        drive_req(1, 1'b1, 4'd1, 32'd3, 32'd3, 5'd0);
        @(negedge clk);
        check("rr_reset_req0", 32'(req0_ready), 32'd1);
        check("rr_reset_req1", 32'(req1_ready), 32'd0);
        tick();

        // Randomized run from a clean reset
        do_reset();
        run_random(1500);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
